regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the y_risc core. It succeeds the single-write, two-read register file.
- Configurable data width, register count, read-port count and write-port count.
- Register 0 is hardwired to zero.
- Optional same-cycle write-to-read bypass.
- Built-in busy-bit scoreboard, so the issue stage can detect RAW hazards for a dual-issue pipeline.

---
 rtl/rv_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 61 ++++++
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared y_risc integer-datapath types and defaults.
package rv_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;

    typedef logic [4:0]          reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the multi-port register file: tracks pending producers per
// register and keeps a registered count of busy registers.
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int unsigned NUM_REGS = NREG_DEF,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iss_en_i,
    input  logic [AW-1:0]        iss_addr_i,
    input  logic [NUM_WR-1:0]    wr_en_i,
    input  logic [NUM_WR*AW-1:0] wr_addr_i,
    input  logic                 flush_i,
    output logic [NUM_REGS-1:0]  busy_o,
    output logic [AW:0]          busy_cnt_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [AW:0]         cnt_q, cnt_d;

    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en_i[p]) begin
                busy_d[wr_addr_i[p*AW +: AW]] = 1'b0;
            end
        end
        // Set after clear: a newly issued producer supersedes a completing one.
        if (iss_en_i) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero and a busy-bit scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_mp
    import rv_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NUM_REGS = NREG_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_WR-1:0]      wr_en_i,
    input  logic [NUM_WR*AW-1:0]   wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0] wr_data_i,
    input  logic [NUM_RD*AW-1:0]   rd_addr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      rd_busy_o,
    input  logic                   iss_en_i,
    input  logic [AW-1:0]          iss_addr_i,
    input  logic                   flush_i,
    output logic [AW:0]            busy_cnt_o
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [AW-1:0]       ra;
    logic [XLEN-1:0]     rdata;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .flush_i    (flush_i),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt_o)
    );

    // Ports are applied in ascending order so the higher-indexed port wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] != '0)) begin
                    regs_q[wr_addr_i[p*AW +: AW]] <= wr_data_i[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        ra        = '0;
        rdata     = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra    = rd_addr_i[p*AW +: AW];
            rdata = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == ra)) begin
                    rdata = wr_data_i[w*XLEN +: XLEN];
                end
            end
`endif
            // Outputs are forced quiet while reset is held, even if a bypass would match.
            if ((ra == '0) || !rst_n) begin
                rdata = '0;
            end
            rd_data_o[p*XLEN +: XLEN] = rdata;
            rd_busy_o[p]              = busy[ra] & rst_n;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a driver pushes model-predicted outputs each cycle,
// a monitor pops and compares them on the falling edge.
module tb_regfile_mp;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int NUM_WR   = 2;
    localparam int AW       = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic                   flush;
    logic [AW:0]            busy_cnt;

    regfile_mp #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .flush_i    (flush),
        .busy_cnt_o (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_RD*XLEN-1:0] data;
        logic [NUM_RD-1:0]      busy;
        logic [AW:0]            cnt;
        string                  tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: architectural register contents and pending-producer set.
    logic [XLEN-1:0] mem [NUM_REGS];
    bit              pend [NUM_REGS];

    function automatic int pend_count();
        int n = 0;
        for (int i = 0; i < NUM_REGS; i++) n += pend[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [XLEN-1:0] model_read(input int a);
        logic [XLEN-1:0] v;
        if (a == 0 || !rst_n) return '0;
        v = mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++)
            if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) v = wr_data[w*XLEN +: XLEN];
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
    endtask

    task automatic push_expect(input string tag);
        exp_t e;
        e.data = '0;
        e.busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            e.data[p*XLEN +: XLEN] = model_read(int'(rd_addr[p*AW +: AW]));
            e.busy[p] = rst_n && pend[int'(rd_addr[p*AW +: AW])];
        end
        e.cnt = rst_n ? (AW+1)'(pend_count()) : '0;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    // Push the expectation for the applied inputs, clock once, then advance the model.
    task automatic step(input string tag);
        push_expect(tag);
        @(posedge clk);
        if (rst_n) begin
            for (int w = 0; w < NUM_WR; w++)
                if (wr_en[w] && wr_addr[w*AW +: AW] != 0)
                    mem[int'(wr_addr[w*AW +: AW])] = wr_data[w*XLEN +: XLEN];
            if (flush) begin
                for (int i = 0; i < NUM_REGS; i++) pend[i] = 1'b0;
            end else begin
                for (int w = 0; w < NUM_WR; w++)
                    if (wr_en[w]) pend[int'(wr_addr[w*AW +: AW])] = 1'b0;
                if (iss_en && iss_addr != 0) pend[int'(iss_addr)] = 1'b1;
            end
        end
        #1;
        idle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total += 3;
                if (rd_data !== e.data) begin
                    bad++;
                    $display("FAIL %s rd_data: got %h want %h", e.tag, rd_data, e.data);
                end
                if (rd_busy !== e.busy) begin
                    bad++;
                    $display("FAIL %s rd_busy: got %b want %b", e.tag, rd_busy, e.busy);
                end
                if (busy_cnt !== e.cnt) begin
                    bad++;
                    $display("FAIL %s busy_cnt: got %0d want %0d", e.tag, busy_cnt, e.cnt);
                end
            end
        end
    end

    initial begin : driver
        int waits;
        rst_n   = 1'b0;
        rd_addr = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int a = 0; a < NUM_REGS; a++) begin
            set_rd(0, a); set_rd(1, NUM_REGS - 1 - a);
            step("reset_read");
        end

        set_wr(0, 5, 32'hDEADBEEF); set_wr(1, 6, 32'h12345678);
        step("wr_x5_x6");
        set_wr(0, 0, 32'hFFFFFFFF); set_rd(0, 5); set_rd(1, 6);
        step("rd_x5_x6");
        set_rd(0, 0); set_rd(1, 5);
        step("rd_x0");

        set_wr(0, 7, 32'hAAAA0000); set_wr(1, 7, 32'h0000BBBB); set_rd(0, 7); set_rd(1, 7);
        step("ww_collide_same");
        set_rd(0, 7);
        step("ww_collide_after");

        iss_en = 1'b1; iss_addr = 3; set_rd(0, 3); set_rd(1, 4);
        step("iss_x3");
        iss_en = 1'b1; iss_addr = 4;
        step("iss_x4");
        set_wr(0, 3, 32'h33); iss_en = 1'b1; iss_addr = 3;
        step("set_wins");
        set_wr(1, 3, 32'h34);
        step("clear_x3");
        iss_en = 1'b1; iss_addr = 3;
        step("reiss_x3");
        iss_en = 1'b1; iss_addr = 9; set_rd(0, 9); set_rd(1, 10);
        step("iss_x9");
        flush = 1'b1; iss_en = 1'b1; iss_addr = 10; set_wr(0, 11, 32'h1111);
        step("flush");
        set_rd(0, 10); set_rd(1, 11);
        step("post_flush");

        set_wr(0, 12, 32'h55); iss_en = 1'b1; iss_addr = 12; set_rd(0, 12); set_rd(1, 5);
        step("wr_x12");
        iss_en = 1'b1; iss_addr = 5;
        step("iss_x5");

        // Mid-cycle asynchronous reset with a write and an issue in flight.
        set_wr(1, 12, 32'h99); iss_en = 1'b1; iss_addr = 13;
        #2;
        rst_n = 1'b0;
        model_reset();
        step("async_reset");
        rst_n = 1'b1;
        set_rd(0, 12); set_rd(1, 5);
        step("after_reset");
        set_wr(0, 13, 32'hCAFEF00D);
        step("first_wr");
        set_rd(0, 13); set_rd(1, 12);
        step("first_wr_rd");

        for (int n = 0; n < 400; n++) begin
            for (int w = 0; w < NUM_WR; w++)
                if ($urandom_range(0, 2) != 0)
                    set_wr(w, (n % 4 == 0) ? $urandom_range(0, 3) : $urandom_range(0, NUM_REGS - 1),
                           $urandom);
            iss_en   = ($urandom_range(0, 1) == 1);
            iss_addr = AW'($urandom_range(0, NUM_REGS - 1));
            flush    = ($urandom_range(0, 31) == 0);
            for (int p = 0; p < NUM_RD; p++) set_rd(p, $urandom_range(0, NUM_REGS - 1));
            step("random");
        end

        waits = 0;
        while (exp_q.size() != 0 && waits < 10) begin
            @(posedge clk);
            waits++;
        end
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
